// File: rtl/syscall_unit.sv
// syscall_unit: syscall decoder with output FIFO, Hex register, ordered halt; optional SYSCALL_COUNT_EN accepted-syscall counter
module syscall_unit #(
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Enable,
  input  logic [31:0]       v0,
  input  logic [DATA_W-1:0] a0,
  output logic              Stall,
  output logic              Halt,
  output logic [DATA_W-1:0] Hex,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_kind,
  output logic [DATA_W-1:0] out_data,
  output logic              Err,
  output logic [31:0]       SyscallCount
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic mem_kind [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count, count_n;
  logic is_int, is_chr, is_hex, is_exit, is_bad, full, acc, push, pop;
  always_comb begin
    is_int = v0 == 32'd1;
    is_chr = v0 == 32'd11;
    is_hex = v0 == 32'd34;
    is_exit = v0 == HALT_CODE;
    is_bad = !(is_int || is_chr || is_hex || is_exit);
    full = count == (AW+1)'(FIFO_DEPTH);
    Stall = state == RUN ? Enable & (is_int | is_chr) & full : Enable;
    acc = Enable & !Stall & (state == RUN);
    push = acc & (is_int | is_chr);
    pop = out_valid & out_ready;
    count_n = count + (AW+1)'(push) - (AW+1)'(pop);
    state_n = state == RUN && acc && is_exit ? (count_n != '0 ? DRAIN : HALTED) :
              state == DRAIN && pop && count == (AW+1)'(1) ? HALTED : state;
  end
  assign out_valid = count != '0;
  assign out_data = mem_data[rp];
  assign out_kind = mem_kind[rp];
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wp] <= is_chr ? {{(DATA_W-8){1'b0}}, a0[7:0]} : a0;
      mem_kind[wp] <= is_chr;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wp <= '0;
      rp <= '0;
      count <= '0;
      Halt <= 1'b0;
      Hex <= '0;
      Err <= 1'b0;
    end else begin
      state <= state_n;
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      count <= count_n;
      Halt <= Halt | (state_n == HALTED);
      Hex <= acc && is_hex ? a0 : Hex;
      Err <= Err | (acc & is_bad);
    end
  end
`ifdef SYSCALL_COUNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk) cnt <= rst ? '0 : cnt + {31'd0, acc};
  assign SyscallCount = cnt;
`else
  assign SyscallCount = '0;
`endif
endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: directed self-checking bench for syscall_unit
module tb_syscall_unit;
`ifdef SYSCALL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk, rst, Enable, out_ready;
  logic [31:0] v0, a0;
  logic Stall, Halt, out_valid, out_kind, Err;
  logic [31:0] Hex, out_data, SyscallCount;
  int checks = 0, errors = 0;

  syscall_unit dut (
    .clk(clk), .rst(rst), .Enable(Enable), .v0(v0), .a0(a0), .Stall(Stall), .Halt(Halt),
    .Hex(Hex), .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_data(out_data), .Err(Err), .SyscallCount(SyscallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    Enable = 1'b0; v0 = '0; a0 = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic call(input logic [31:0] code, input logic [31:0] arg);
    Enable = 1'b1; v0 = code; a0 = arg;
    tick();
    Enable = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (Hex !== 32'h0) begin errors++; $display("FAIL reset_hex: got %h want 0", Hex); end
    checks++; if (Halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", Halt); end
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", Err); end
    checks++; if (SyscallCount !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", SyscallCount); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
  endtask

  task automatic test_hex;
    do_reset();
    Enable = 1'b1; v0 = 32'd34; a0 = 32'h1234ABCD;
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL hex_stall: got %b want 0", Stall); end
    tick();
    Enable = 1'b0;
    checks++; if (Hex !== 32'h1234ABCD) begin errors++; $display("FAIL hex_value: got %h want 1234abcd", Hex); end
    checks++; if (Halt !== 1'b0) begin errors++; $display("FAIL hex_halt: got %b want 0", Halt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hex_fifo: got %b want 0", out_valid); end
    checks++; if (SyscallCount !== (CNT_EN ? 32'd1 : 32'd0)) begin errors++; $display("FAIL hex_count: got %0d want %0d", SyscallCount, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_fifo_full;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      Enable = 1'b1; v0 = 32'd1; a0 = i;
      #1;
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL full_accept%0d: stall got %b want 0", i, Stall); end
      tick();
    end
    a0 = 32'd5;
    #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", Stall); end
    tick();
    out_ready = 1'b1;
    #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL full_no_bypass: got %b want 1", Stall); end
    checks++; if (out_data !== 32'd1) begin errors++; $display("FAIL full_head1: got %0d want 1", out_data); end
    tick();
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL full_retry: got %b want 0", Stall); end
    checks++; if (out_data !== 32'd2) begin errors++; $display("FAIL full_head2: got %0d want 2", out_data); end
    tick();
    Enable = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== i || out_kind !== 1'b0) begin errors++; $display("FAIL full_head%0d: valid %b kind %b data %0d want 1 0 %0d", i, out_valid, out_kind, out_data, i); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b want 0", out_valid); end
    checks++; if (SyscallCount !== (CNT_EN ? 32'd5 : 32'd0)) begin errors++; $display("FAIL full_count: got %0d want %0d", SyscallCount, CNT_EN ? 5 : 0); end
  endtask

  task automatic test_char;
    do_reset();
    call(32'd11, 32'hFFFFFF41);
    checks++; if (out_valid !== 1'b1 || out_kind !== 1'b1 || out_data !== 32'h41) begin errors++; $display("FAIL char_head: valid %b kind %b data %h want 1 1 00000041", out_valid, out_kind, out_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h41) begin errors++; $display("FAIL char_hold: valid %b data %h want 1 00000041", out_valid, out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL char_pop: got %b want 0", out_valid); end
  endtask

  task automatic test_exit_drain;
    do_reset();
    call(32'd1, 32'd10);
    call(32'd1, 32'd20);
    call(32'd10, 32'd0);
    checks++; if (Halt !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL drain_enter: halt %b valid %b want 0 1", Halt, out_valid); end
    Enable = 1'b1; v0 = 32'd1; a0 = 32'd30;
    #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL drain_stall: got %b want 1", Stall); end
    Enable = 1'b0;
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL drain_stall_idle: got %b want 0", Stall); end
    out_ready = 1'b1;
    tick();
    checks++; if (Halt !== 1'b0 || out_data !== 32'd20) begin errors++; $display("FAIL drain_pop1: halt %b data %0d want 0 20", Halt, out_data); end
    tick();
    out_ready = 1'b0;
    checks++; if (Halt !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_halt: halt %b valid %b want 1 0", Halt, out_valid); end
    for (int i = 0; i < 2; i++) begin
      Enable = 1'b1; v0 = 32'd34; a0 = 32'h55;
      #1;
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL halted_stall%0d: got %b want 1", i, Stall); end
      tick();
      Enable = 1'b0;
      tick();
      checks++; if (Halt !== 1'b1 || Hex !== 32'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL halted_sticky%0d: halt %b hex %h valid %b want 1 0 0", i, Halt, Hex, out_valid); end
    end
    do_reset();
    call(32'd10, 32'd0);
    checks++; if (Halt !== 1'b1) begin errors++; $display("FAIL exit_empty: got %b want 1", Halt); end
  endtask

  task automatic test_unknown;
    do_reset();
    call(32'd7, 32'hDEAD);
    checks++; if (Err !== 1'b1 || Hex !== 32'h0 || out_valid !== 1'b0 || Halt !== 1'b0) begin errors++; $display("FAIL unk_effect: err %b hex %h valid %b halt %b want 1 0 0 0", Err, Hex, out_valid, Halt); end
    checks++; if (SyscallCount !== (CNT_EN ? 32'd1 : 32'd0)) begin errors++; $display("FAIL unk_count: got %0d want %0d", SyscallCount, CNT_EN ? 1 : 0); end
    call(32'd1, 32'd9);
    tick();
    checks++; if (Err !== 1'b1 || out_data !== 32'd9) begin errors++; $display("FAIL unk_sticky: err %b data %0d want 1 9", Err, out_data); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    call(32'd34, 32'h77);
    call(32'd7, 32'd0);
    for (int i = 1; i <= 3; i++) call(32'd1, i);
    rst = 1'b1; out_ready = 1'b1; Enable = 1'b1; v0 = 32'd1; a0 = 32'd99;
    tick();
    rst = 1'b0; idle();
    checks++; if (out_valid !== 1'b0 || Hex !== 32'h0 || Halt !== 1'b0 || Err !== 1'b0 || SyscallCount !== 32'h0) begin errors++; $display("FAIL rst_mid: valid %b hex %h halt %b err %b count %0d want all 0", out_valid, Hex, Halt, Err, SyscallCount); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_nopush: got %b want 0", out_valid); end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_hex();
    test_fifo_full();
    test_char();
    test_exit_drain();
    test_unknown();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Parametrised successor to the single-purpose syscall decoder in the MIPS CPU.
- Decodes the service code in v0 when a syscall is executed. Handles these services:
  - print-int and print-char: queued into an output FIFO drained by a console/display sink over a valid/ready handshake.
  - print-hex: loaded directly into the Hex display register.
  - exit: ordered halt.
- Sits beside the register file in the execute stage. Drives Stall back to the pipeline when it cannot accept a syscall.

Parameters:
- DATA_W, 32, width of a0, Hex and out_data.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
- HALT_CODE, 10, v0 value requesting exit.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- Enable  input  1  syscall instruction present this cycle.
- v0  input  32  service code.
- a0  input  DATA_W  argument.
- Stall  output  1  combinational; pipeline must hold the syscall and retry next cycle.
- Halt  output  1  registered; CPU stops.
- Hex  output  DATA_W  registered display value.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  sink accepts head.
- out_kind  output  1  0 = integer, 1 = character.
- out_data  output  DATA_W  FIFO head payload.
- Err  output  1  sticky: an unknown service code was seen.
- SyscallCount  output  32  accepted-syscall counter (see Optional Feature).

Behaviour:
- Reset values: Hex=0, Halt=0, Err=0, out_valid=0, FIFO empty, SyscallCount=0, state=RUN.
- Service codes, compared on the full 32 bits of v0:
  - 1 = print-int
  - 11 = print-char
  - 34 = print-hex
  - HALT_CODE = exit
  - any other value = unknown
- Accepted: Enable=1 and Stall=0 in the same cycle.
- States:
  - RUN
  - DRAIN: exit seen, FIFO not yet empty.
  - HALTED
- RUN, accepted syscall:
  - print-int: push {kind=0, a0}.
  - print-char: push {kind=1, zero-extended a0[7:0]}.
  - print-hex: Hex<=a0 on this edge (1-cycle latency).
  - exit: go to DRAIN if the FIFO is non-empty after this cycle's pop, else go straight to HALTED.
  - unknown: Err<=1; no other effect.
- Stall:
  - RUN: Stall = Enable & (print-int | print-char) & full.
  - No pop-bypass: a push is refused while the FIFO is full even if out_ready=1 this cycle.
  - Stall = Enable in DRAIN and in HALTED.
- DRAIN: pops continue. Go to HALTED on the edge where the last entry pops (count 1 with out_ready=1).
- HALTED:
  - Halt=1, sticky until rst.
  - FIFO empty, Enable ignored, Stall=Enable.
- Halt timing: asserts the cycle after HALTED is entered. It never rises while FIFO entries remain.
- FIFO handshake:
  - Pop occurs when out_valid & out_ready.
  - out_valid = non-empty.
  - out_kind and out_data show the head, stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop when 0 < count < FIFO_DEPTH: count unchanged, order preserved.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Push when empty: out_valid=1 the next cycle (no fall-through).
- rst mid-operation: FIFO contents discarded, state to RUN, all outputs to reset values on that edge. rst dominates Enable.

Optional Feature:
- Macro: SYSCALL_COUNT_EN.
- Defined: SyscallCount increments by 1 on every accepted syscall, including exit and unknown codes. It wraps at 2^32 and clears on rst.
- Not defined: the counter logic is omitted and SyscallCount is tied to 0. All other behaviour is identical.

Test Plan:
- rst; Enable, v0=34, a0=0x1234ABCD → Hex=0x1234ABCD the next cycle; Halt=0; FIFO stays empty.
- out_ready=0; five print-int syscalls, a0=1..5, FIFO_DEPTH=4 → first four accepted, fifth sees Stall=1. Raise out_ready → out_data sequence 1,2,3,4; the fifth is accepted after the first pop, then outputs 5.
- Print-char, a0=0xFFFFFF41 → out_kind=1, out_data=0x00000041.
- Two print-ints queued, out_ready=0, then exit → state DRAIN, Stall=Enable, Halt=0. Pulse out_ready twice → Halt=1 the cycle after the second pop. Halt stays 1 through further Enable pulses.
- v0=7 → Err=1 and stays set; Hex, FIFO and Halt unchanged. With SYSCALL_COUNT_EN defined, SyscallCount=1. Without it, SyscallCount=0.
- Three entries queued; assert rst for one cycle while out_ready=1 and Enable=1 (print-int) → the next cycle shows out_valid=0, Hex=0, Halt=0, Err=0, SyscallCount=0.
